// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory BIST controller.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef logic [2:0] elem_t;

    typedef enum logic [1:0] {
        W0,
        W1,
        R0,
        R1
    } op_e;

    // desc selects ~q addressing; op1 is only used when two_ops is set
    typedef struct packed {
        logic desc;
        logic two_ops;
        op_e  op0;
        op_e  op1;
    } elem_cfg_t;

    localparam int    NUM_ELEMS = 6;
    localparam elem_t LAST_ELEM = elem_t'(NUM_ELEMS - 1);

    localparam elem_cfg_t MARCH_TBL [NUM_ELEMS] = '{
        '{desc: 1'b0, two_ops: 1'b0, op0: W0, op1: W0},
        '{desc: 1'b0, two_ops: 1'b1, op0: R0, op1: W1},
        '{desc: 1'b0, two_ops: 1'b1, op0: R1, op1: W0},
        '{desc: 1'b1, two_ops: 1'b1, op0: R0, op1: W1},
        '{desc: 1'b1, two_ops: 1'b1, op0: R1, op1: W0},
        '{desc: 1'b0, two_ops: 1'b0, op0: R0, op1: R0}
    };

    function automatic logic op_is_read(input op_e op);
        return (op == R0) || (op == R1);
    endfunction

    function automatic logic op_data_one(input op_e op);
        return (op == W1) || (op == R1);
    endfunction

endpackage

// File: rtl/bist_counter.sv
// Loadable up-counter used as the BIST address generator; cout flags terminal count.
module bist_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         ld,
    input  logic         cen,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q,
    output logic         cout
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (ld) begin
            r_q <= d_in;
        end else if (cen) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q    = r_q;
    assign cout = &r_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: one memory operation per cycle, read compare
// overlapped with the following operation, stop on first mismatch.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_e            r_state;
    state_e            w_state_nxt;
    elem_t             r_elem;
    logic              r_opi;
    logic              r_ops_done;
    logic              r_fail;
    logic              r_done;
    logic [ADDR_W-1:0] r_fail_addr;
    elem_t             r_fail_elem;

    logic              r_vld_p1;
    logic              r_last_p1;
    logic [DATA_W-1:0] r_exp_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    elem_t             r_elem_p1;

    elem_cfg_t         w_cfg;
    op_e               w_op;
    logic              w_issue;
    logic              w_rd_issue;
    logic              w_op_last;
    logic              w_run_last;
    logic              w_mismatch;
    logic [ADDR_W-1:0] w_addr;
    logic              w_cnt_ld;
    logic              w_cnt_cen;
    logic              w_ld;
    logic [ADDR_W-1:0] w_cnt_q;
    logic              w_cnt_cout;

    assign w_ld = w_cnt_ld | reset;

    bist_counter #(
        .W(ADDR_W)
    ) u_cnt (
        .clk (clk),
        .ld  (w_ld),
        .cen (w_cnt_cen),
        .d_in({ADDR_W{1'b0}}),
        .q   (w_cnt_q),
        .cout(w_cnt_cout)
    );

    assign w_cfg      = (r_elem < elem_t'(NUM_ELEMS)) ? MARCH_TBL[r_elem] : MARCH_TBL[0];
    assign w_op       = r_opi ? w_cfg.op1 : w_cfg.op0;
    assign w_issue    = (r_state == RUN) && !r_ops_done;
    assign w_rd_issue = w_issue && op_is_read(w_op);
    assign w_op_last  = (r_opi == w_cfg.two_ops);
    assign w_addr     = w_cfg.desc ? ~w_cnt_q : w_cnt_q;
    assign w_run_last = w_issue && w_op_last && w_cnt_cout && (r_elem == LAST_ELEM);
    assign w_mismatch = r_vld_p1 && (mem_rdata != r_exp_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_ld    = 1'b0;
        w_cnt_cen   = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = '0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_cnt_ld    = 1'b1;
                end
            end
            RUN: begin
                if (w_issue) begin
                    mem_addr = w_addr;
                    mem_re   = op_is_read(w_op);
                    mem_we   = !op_is_read(w_op);
                    if (!op_is_read(w_op) && op_data_one(w_op)) begin
                        mem_wdata = '1;
                    end
                    if (w_op_last) begin
                        w_cnt_ld  = w_cnt_cout;
                        w_cnt_cen = !w_cnt_cout;
                    end
                end
                if (w_mismatch || (r_vld_p1 && r_last_p1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_elem      <= '0;
            r_opi       <= 1'b0;
            r_ops_done  <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_last_p1   <= 1'b0;
            r_fail      <= 1'b0;
            r_done      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
        end else if (r_state != RUN) begin
            if (start) begin
                r_elem      <= '0;
                r_opi       <= 1'b0;
                r_ops_done  <= 1'b0;
                r_vld_p1    <= 1'b0;
                r_last_p1   <= 1'b0;
                r_fail      <= 1'b0;
                r_done      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
            end
        end else begin
            if (w_issue) begin
                r_opi <= !w_op_last;
                if (w_op_last && w_cnt_cout) begin
                    if (r_elem == LAST_ELEM) begin
                        r_ops_done <= 1'b1;
                    end else begin
                        r_elem <= r_elem + elem_t'(1);
                    end
                end
            end
            // p1: a read issued this cycle is checked against mem_rdata next cycle
            r_vld_p1  <= w_rd_issue && (w_state_nxt == RUN);
            r_last_p1 <= w_run_last;
            if (w_mismatch) begin
                r_fail      <= 1'b1;
                r_done      <= 1'b1;
                r_fail_addr <= r_addr_p1;
                r_fail_elem <= r_elem_p1;
            end else if (r_vld_p1 && r_last_p1) begin
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_issue) begin
            r_exp_p1  <= op_data_one(w_op) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            r_addr_p1 <= w_addr;
            r_elem_p1 <= r_elem;
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: expected March C- operation streams are
// queued at start and matched against the strobes the controllers issue.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start2 = 1'b0;
    logic       start1 = 1'b0;
    bit         fault = 1'b0;

    logic [1:0] addr2;
    logic       we2, re2, busy2, done2, fail2;
    logic [7:0] wd2;
    logic [7:0] rd2 = 8'h00;
    logic [1:0] faddr2;
    logic [2:0] felem2;

    logic [0:0] addr1;
    logic       we1, re1, busy1, done1, fail1;
    logic [7:0] wd1;
    logic [7:0] rd1 = 8'h00;
    logic [0:0] faddr1;
    logic [2:0] felem1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [1:0] addr;
        logic [7:0] wd;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];
    exp_t c2, c1;

    int op0_tbl[6] = '{0, 2, 3, 2, 3, 2};
    int op1_tbl[6] = '{-1, 1, 0, 1, 0, -1};

    logic [7:0] mem2[4];
    logic [7:0] mem1[2];

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .mem_addr(addr2), .mem_we(we2), .mem_re(re2), .mem_wdata(wd2), .mem_rdata(rd2),
        .busy(busy2), .done(done2), .fail(fail2), .fail_addr(faddr2), .fail_elem(felem2)
    );

    mbist_march_ctrl #(.ADDR_W(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .mem_addr(addr1), .mem_we(we1), .mem_re(re1), .mem_wdata(wd1), .mem_rdata(rd1),
        .busy(busy1), .done(done1), .fail(fail1), .fail_addr(faddr1), .fail_elem(felem1)
    );

    // Memory models: registered read data; optional stuck-at-1 on bit0 of word 2
    always @(posedge clk) begin
        if (re2) rd2 <= mem2[addr2] | ((fault && addr2 == 2'd2) ? 8'h01 : 8'h00);
        if (we2) mem2[addr2] <= wd2;
        if (re1) rd1 <= mem1[addr1];
        if (we1) mem1[addr1] <= wd1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        assert (!(we2 && re2));
        assert (!(we1 && re1));
        if (we2 || re2) begin
            check("we_re_excl2", {63'd0, we2 & re2}, 64'd0);
            if (q2.size() == 0) begin
                check("unexp_op2", {62'd0, we2, re2}, 64'd0);
            end else begin
                c2 = q2.pop_front();
                check("op2", {we2, re2, addr2, wd2}, c2);
            end
        end
        if (we1 || re1) begin
            check("we_re_excl1", {63'd0, we1 & re1}, 64'd0);
            if (q1.size() == 0) begin
                check("unexp_op1", {62'd0, we1, re1}, 64'd0);
            end else begin
                c1 = q1.pop_front();
                check("op1", {we1, re1, 1'b0, addr1, wd1}, c1);
            end
        end
    end

    task automatic push_ops(input bit use1, input int aw, input int limit);
        int   n;
        int   cnt;
        int   op;
        int   a;
        exp_t e;
        n   = 1 << aw;
        cnt = 0;
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 2; j++) begin
                    op = (j != 0) ? op1_tbl[el] : op0_tbl[el];
                    if (op >= 0) begin
                        a      = (el == 3 || el == 4) ? (n - 1 - i) : i;
                        e.we   = (op < 2);
                        e.re   = (op >= 2);
                        e.addr = a[1:0];
                        e.wd   = (op == 1) ? 8'hFF : 8'h00;
                        if (cnt < limit) begin
                            if (use1) q1.push_back(e);
                            else      q2.push_back(e);
                        end
                        cnt++;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input bit use1);
        if (use1) start1 = 1'b1;
        else      start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit use1, input bit repulse, output int k);
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (repulse && k == 4) start2 = 1'b1;
            if (repulse && k == 5) start2 = 1'b0;
            if (use1 ? done1 : done2) break;
        end
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_fail", fail2, 0);
        check("rst_faddr", faddr2, 0);
        check("rst_felem", felem2, 0);
        check("rst_addr", addr2, 0);
        check("rst_we_re", {we2, re2}, 0);
        check("rst_wdata", wd2, 0);
        reset = 1'b0;

        // fault-free run, ADDR_W=2
        push_ops(1'b0, 2, 40);
        pulse_start(1'b0);
        check("s1_busy", busy2, 1);
        wait_done(1'b0, 1'b0, k);
        check("s1_done_edge", k, 41);
        check("s1_fail", fail2, 0);
        check("s1_busy_end", busy2, 0);
        check("s1_queue", q2.size(), 0);

        // stuck-at-1 on word 2 bit0: mismatch on op 9
        fault = 1'b1;
        push_ops(1'b0, 2, 10);
        pulse_start(1'b0);
        wait_done(1'b0, 1'b0, k);
        check("s2_done_edge", k, 10);
        check("s2_fail", fail2, 1);
        check("s2_faddr", faddr2, 2);
        check("s2_felem", felem2, 1);
        check("s2_busy", busy2, 0);
        repeat (5) @(posedge clk);
        #1;
        check("s2_done_held", done2, 1);
        check("s2_queue", q2.size(), 0);

        // start from DONE clears fail; a start pulse mid-run is ignored
        fault = 1'b0;
        push_ops(1'b0, 2, 40);
        pulse_start(1'b0);
        check("s3_fail_clr", fail2, 0);
        check("s3_faddr_clr", faddr2, 0);
        check("s3_felem_clr", felem2, 0);
        check("s3_done_clr", done2, 0);
        check("s3_busy", busy2, 1);
        wait_done(1'b0, 1'b1, k);
        check("s3_done_edge", k, 41);
        check("s3_fail", fail2, 0);
        check("s3_queue", q2.size(), 0);

        // reset during op 15
        push_ops(1'b0, 2, 15);
        pulse_start(1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s4_busy", busy2, 0);
        check("s4_done", done2, 0);
        check("s4_fail", fail2, 0);
        check("s4_addr", addr2, 0);
        check("s4_we_re", {we2, re2}, 0);
        check("s4_wdata", wd2, 0);
        check("s4_queue", q2.size(), 0);
        reset = 1'b0;
        push_ops(1'b0, 2, 40);
        pulse_start(1'b0);
        wait_done(1'b0, 1'b0, k);
        check("s4_rerun_edge", k, 41);
        check("s4_rerun_fail", fail2, 0);
        check("s4_rerun_queue", q2.size(), 0);

        // ADDR_W=1 fault-free
        push_ops(1'b1, 1, 20);
        pulse_start(1'b1);
        wait_done(1'b1, 1'b0, k);
        check("s5_done_edge", k, 21);
        check("s5_fail", fail1, 0);
        check("s5_queue", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
